instr_fetch_unit: RTL

//  Front end of the RISC-V core: owns the PC and fetches instruction words from instruction memory.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/response, and the {instr, pc} decode port.
// Suffixes are from the fetch unit's point of view; the master modport is the fetch unit itself.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;
  logic                  imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic                  imem_gnt_i;
  logic                  imem_rvalid_i;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic                  instr_valid_o;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0] instr_pc_o;
  logic                  instr_ready_i;

  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC owner and instruction fetcher: one outstanding imem request, words land in a small FIFO, no bypass (>=1 cycle rvalid->instr_o).
// Backpressure: requests are issued only while FIFO entries plus the in-flight request leave room; a redirect flushes everything.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_unit_if.master   bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DROP} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] tag_q;
  logic [DATA_WIDTH-1:0] dat_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] last_dat_q;
  logic [ADDR_WIDTH-1:0] last_pc_q;

  logic                  outstanding;
  logic [CNT_W:0]        used;
  logic                  credit_ok;
  logic                  req;
  logic                  fire;
  logic                  push;
  logic                  pop;
  logic                  head_vld;
  logic [ADDR_WIDTH-1:0] redirect_tgt;

  assign outstanding  = (state_q == WAIT) || (state_q == DROP);
  assign used         = {1'b0, cnt_q} + {{CNT_W{1'b0}}, outstanding};
  assign credit_ok    = used < (CNT_W+1)'(FIFO_DEPTH);
  assign req          = (state_q == FETCH) && credit_ok;
  assign fire         = req && bus.imem_gnt_i;
  assign head_vld     = cnt_q != '0;
  assign redirect_tgt = bus.redirect_pc_i & ~ADDR_WIDTH'(3);

  // Redirect wins over both FIFO ports: the returning word and the head are stale.
  assign push = (state_q == WAIT) && bus.imem_rvalid_i && !bus.redirect_i;
  assign pop  = head_vld && bus.instr_ready_i && !bus.redirect_i;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.redirect_i)
      cnt_d = '0;
    else if (push && !pop)
      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      tag_q      <= '0;
    end else begin
      if (bus.redirect_i)
        fetch_pc_q <= redirect_tgt;
      else if (fire)
        fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
      if (fire)
        tag_q <= fetch_pc_q;
      case (state_q)
        IDLE:    state_q <= FETCH;
        FETCH:   if (fire) state_q <= bus.redirect_i ? DROP : WAIT;
        // Data returning in the redirect cycle closes the request, so no DROP is needed then.
        WAIT:    if (bus.imem_rvalid_i) state_q <= FETCH;
                 else if (bus.redirect_i) state_q <= DROP;
        DROP:    if (bus.imem_rvalid_i) state_q <= FETCH;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      last_dat_q <= NOP;
      last_pc_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      last_dat_q <= bus.instr_o;
      last_pc_q  <= bus.instr_pc_o;
      if (bus.redirect_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dat_q[wr_ptr_q] <= bus.imem_rdata_i;
      pc_q[wr_ptr_q]  <= tag_q;
    end
  end

  // An empty FIFO keeps presenting whatever was shown last.
  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = head_vld;
  assign bus.instr_o       = head_vld ? dat_q[rd_ptr_q] : last_dat_q;
  assign bus.instr_pc_o    = head_vld ? pc_q[rd_ptr_q]  : last_pc_q;

endmodule
